// File: rtl/custom_ip_reg_if.sv
// APB register bridge to three IP channels: write strobes toward the IP, shadowed capture
// from the IP with valid flags, blocking reads with timeout, and a W1C STATUS register.
module custom_ip_reg_if #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [3:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [95:0] reg2ip_data_o,
    output logic [2:0]  reg2ip_en_o,
    input  logic [95:0] ip2reg_data_i,
    input  logic [2:0]  ip2reg_en_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StWaitRd, StResp} state_e;

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_shadow [3];
    logic [2:0]  r_valid;
    logic [95:0] r_reg2ip_data;
    logic [2:0]  r_reg2ip_en;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;

    logic        w_is_status;
    logic        w_misaligned;
    logic [2:0]  w_ch_onehot;
    logic [31:0] w_sel_shadow;
    logic [31:0] w_sel_ip_data;
    logic        w_sel_valid;
    logic        w_sel_cap;

    assign w_is_status  = (paddr_i[3:2] == 2'd3);
    assign w_misaligned = (paddr_i[1:0] != 2'd0);

    always_comb begin
        w_ch_onehot   = '0;
        w_sel_shadow  = '0;
        w_sel_ip_data = '0;
        w_sel_valid   = 1'b0;
        w_sel_cap     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (paddr_i[3:2] == 2'(i)) begin
                w_ch_onehot[i] = 1'b1;
                w_sel_shadow   = r_shadow[i];
                w_sel_ip_data  = ip2reg_data_i[32*i +: 32];
                w_sel_valid    = r_valid[i];
                w_sel_cap      = ip2reg_en_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_valid       <= '0;
            r_reg2ip_data <= '0;
            r_reg2ip_en   <= '0;
            r_prdata      <= '0;
            r_pready      <= 1'b0;
            r_pslverr     <= 1'b0;
            for (int i = 0; i < 3; i++) r_shadow[i] <= '0;
        end else begin
            r_reg2ip_en <= '0;
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            // Capture always wins over a same-cycle clear; clears below OR the capture back in.
            r_valid     <= r_valid | ip2reg_en_i;
            for (int i = 0; i < 3; i++) begin
                if (ip2reg_en_i[i]) r_shadow[i] <= ip2reg_data_i[32*i +: 32];
            end

            unique case (r_state)
                StIdle: begin
                    if (psel_i && !penable_i) r_state <= StAccess;
                end
                StAccess: begin
                    if (!psel_i) begin
                        r_state <= StIdle;
                    end else if (w_misaligned) begin
                        r_state   <= StResp;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                    end else if (pwrite_i) begin
                        r_state  <= StResp;
                        r_pready <= 1'b1;
                        if (w_is_status) begin
                            r_valid <= (r_valid & ~pwdata_i[2:0]) | ip2reg_en_i;
                        end else begin
                            for (int i = 0; i < 3; i++) begin
                                if (w_ch_onehot[i]) r_reg2ip_data[32*i +: 32] <= pwdata_i;
                            end
                            r_reg2ip_en <= w_ch_onehot;
                        end
                    end else if (w_is_status) begin
                        r_state  <= StResp;
                        r_pready <= 1'b1;
                        r_prdata <= {29'd0, r_valid};
                    end else if (w_sel_valid) begin
                        r_state  <= StResp;
                        r_pready <= 1'b1;
                        r_prdata <= w_sel_shadow;
                        r_valid  <= (r_valid & ~w_ch_onehot) | ip2reg_en_i;
                    end else begin
                        r_state <= StWaitRd;
                        r_cnt   <= '0;
                    end
                end
                StWaitRd: begin
                    if (!psel_i) begin
                        r_state <= StIdle;
                    end else if (w_sel_cap) begin
                        r_state  <= StResp;
                        r_pready <= 1'b1;
                        r_prdata <= w_sel_ip_data;
                        r_valid  <= (r_valid & ~w_ch_onehot) | ip2reg_en_i;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        // Last permitted wait cycle: TIMEOUT cycles spent in this state.
                        r_state   <= StResp;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign prdata_o      = r_prdata;
    assign pready_o      = r_pready;
    assign pslverr_o     = r_pslverr;
    assign reg2ip_data_o = r_reg2ip_data;
    assign reg2ip_en_o   = r_reg2ip_en;

endmodule

// File: tb/tb_custom_ip_reg_if.sv
// Directed bench for custom_ip_reg_if: APB transfers with hand-computed expectations.
module tb_custom_ip_reg_if;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [3:0]  paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [95:0] reg2ip_data_o;
    logic [2:0]  reg2ip_en_o;
    logic [95:0] ip2reg_data_i = '0;
    logic [2:0]  ip2reg_en_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    custom_ip_reg_if #(.TIMEOUT(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .psel_i        (psel_i),
        .penable_i     (penable_i),
        .pwrite_i      (pwrite_i),
        .paddr_i       (paddr_i),
        .pwdata_i      (pwdata_i),
        .prdata_o      (prdata_o),
        .pready_o      (pready_o),
        .pslverr_o     (pslverr_o),
        .reg2ip_data_o (reg2ip_data_o),
        .reg2ip_en_o   (reg2ip_en_o),
        .ip2reg_data_i (ip2reg_data_i),
        .ip2reg_en_i   (ip2reg_en_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cap(input logic [2:0] mask, input logic [95:0] data);
        ip2reg_en_i   = mask;
        ip2reg_data_i = data;
        step();
        ip2reg_en_i   = '0;
    endtask

    // One APB transfer; optionally pulses ip2reg_en_i during access cycle number cap_at (0-based).
    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       input int cap_at, input logic [2:0] cap_mask, input logic [95:0] cap_data,
                       output logic [31:0] rd, output logic err, output logic [2:0] en,
                       output int n);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = addr;
        pwdata_i  = wd;
        step();
        penable_i = 1'b1;
        n = 0;
        while (n < 100) begin
            ip2reg_en_i   = (n == cap_at) ? cap_mask : 3'b000;
            ip2reg_data_i = cap_data;
            step();
            n++;
            if (pready_o) break;
        end
        ip2reg_en_i = '0;
        rd  = prdata_o;
        err = pslverr_o;
        en  = reg2ip_en_o;
        chk("pready_seen", {95'd0, pready_o}, 96'd1);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        step();
        chk("pready_one_cycle", {95'd0, pready_o}, 96'd0);
        chk("prdata_idle", {64'd0, prdata_o}, 96'd0);
    endtask

    logic [31:0] rd;
    logic        err;
    logic [2:0]  en;
    int          n;
    logic        seen;

    initial begin
        step();
        step();
        rst_i = 1'b0;
        chk("rst_pready", {95'd0, pready_o}, 96'd0);
        chk("rst_pslverr", {95'd0, pslverr_o}, 96'd0);
        chk("rst_prdata", {64'd0, prdata_o}, 96'd0);
        chk("rst_r2i_data", reg2ip_data_o, 96'd0);
        chk("rst_r2i_en", {93'd0, reg2ip_en_o}, 96'd0);

        apb(1'b1, 4'h4, 32'hDEADBEEF, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("wr1_en", {93'd0, en}, 96'd2);
        chk("wr1_err", {95'd0, err}, 96'd0);
        chk("wr1_lat", 96'(n), 96'd1);
        chk("wr1_data", reg2ip_data_o, {32'd0, 32'hDEADBEEF, 32'd0});
        chk("wr1_en_drop", {93'd0, reg2ip_en_o}, 96'd0);

        apb(1'b1, 4'h0, 32'h11111111, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("wr0_en", {93'd0, en}, 96'd1);
        chk("wr0_data", reg2ip_data_o, {32'd0, 32'hDEADBEEF, 32'h11111111});

        apb(1'b1, 4'h5, 32'hCAFEF00D, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("mis_err", {95'd0, err}, 96'd1);
        chk("mis_en", {93'd0, en}, 96'd0);
        chk("mis_rd", {64'd0, rd}, 96'd0);
        chk("mis_data", reg2ip_data_o, {32'd0, 32'hDEADBEEF, 32'h11111111});

        cap(3'b001, {64'd0, 32'h12345678});
        apb(1'b0, 4'h0, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("rd0_data", {64'd0, rd}, {64'd0, 32'h12345678});
        chk("rd0_err", {95'd0, err}, 96'd0);
        chk("rd0_lat", 96'(n), 96'd1);
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_after_rd0", {64'd0, rd}, 96'd0);

        apb(1'b0, 4'h8, 32'd0, 4, 3'b100, {32'hA5A5A5A5, 64'd0}, rd, err, en, n);
        chk("rd2_wait_data", {64'd0, rd}, {64'd0, 32'hA5A5A5A5});
        chk("rd2_wait_err", {95'd0, err}, 96'd0);
        chk("rd2_wait_lat", 96'(n), 96'd5);

        apb(1'b1, 4'hC, 32'h7, -1, 3'b000, 96'd0, rd, err, en, n);
        apb(1'b0, 4'h8, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("tmo_err", {95'd0, err}, 96'd1);
        chk("tmo_rd", {64'd0, rd}, 96'd0);
        chk("tmo_lat", 96'(n), 96'd17);
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_after_tmo", {64'd0, rd}, 96'd0);

        cap(3'b111, {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_all", {64'd0, rd}, 96'd7);
        apb(1'b1, 4'hC, 32'h5, 0, 3'b001, {64'd0, 32'hAAAA1111}, rd, err, en, n);
        chk("w1c_en", {93'd0, en}, 96'd0);
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_w1c_cap", {64'd0, rd}, 96'd3);
        apb(1'b0, 4'h4, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("rd1_data", {64'd0, rd}, {64'd0, 32'hBBBB0001});
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_after_rd1", {64'd0, rd}, 96'd1);

        // Abandon a read while it waits for capture.
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 4'h8;
        step();
        penable_i = 1'b1;
        step();
        step();
        psel_i = 1'b0; penable_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | pready_o;
        end
        chk("abandon_pready", {95'd0, seen}, 96'd0);
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_after_abandon", {64'd0, rd}, 96'd1);

        // Reset while the read sits in WAIT_RD.
        cap(3'b010, {32'd0, 32'h0000BEEF, 32'd0});
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 4'h8;
        step();
        penable_i = 1'b1;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        chk("mrst_pready", {95'd0, pready_o}, 96'd0);
        chk("mrst_pslverr", {95'd0, pslverr_o}, 96'd0);
        chk("mrst_prdata", {64'd0, prdata_o}, 96'd0);
        chk("mrst_r2i_data", reg2ip_data_o, 96'd0);
        chk("mrst_r2i_en", {93'd0, reg2ip_en_o}, 96'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | pready_o | (|reg2ip_en_o);
        end
        chk("mrst_no_resp", {95'd0, seen}, 96'd0);
        apb(1'b0, 4'hC, 32'd0, -1, 3'b000, 96'd0, rd, err, en, n);
        chk("st_after_mrst", {64'd0, rd}, 96'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/custom_ip_reg_if.md
CUSTOM_IP_REG_IF -- requirements
Module: custom_ip_reg_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT_RD cycles before a read fails (range 1..255).
REQ-002 SHALL have port clk_i  input  1  meaning the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i  input  1  meaning a synchronous, active-high reset.
REQ-004 SHALL have port psel_i  input  1  meaning the APB select.
REQ-005 SHALL have port penable_i  input  1  meaning the APB enable (access phase).
REQ-006 SHALL have port pwrite_i  input  1  meaning the APB direction; 1 = write.
REQ-007 SHALL have port paddr_i  input  4  meaning the byte address.
REQ-008 SHALL have port pwdata_i  input  32  meaning the write data.
REQ-009 SHALL have port prdata_o  output  32  meaning the read data, valid while pready_o=1.
REQ-010 SHALL have port pready_o  output  1  meaning the transfer completes.
REQ-011 SHALL have port pslverr_o  output  1  meaning a transfer error, valid while pready_o=1.
REQ-012 SHALL have port reg2ip_data_o  output  96  meaning channel i value at bits [32i+31:32i].
REQ-013 SHALL have port reg2ip_en_o  output  3  meaning a one-cycle write strobe per channel.
REQ-014 SHALL have port ip2reg_data_i  input  96  meaning the IP-side value per channel, same packing as reg2ip_data_o.
REQ-015 SHALL have port ip2reg_en_i  input  3  meaning a capture strobe per channel.

Function
REQ-016 SHALL decode the address map as: paddr_i[3:2]=0,1,2 selects channel 0,1,2; paddr_i[3:2]=3 selects STATUS.
REQ-017 SHALL define STATUS as bits[2:0]=valid[2:0] and bits[31:3]=0.
REQ-018 SHALL treat any access with paddr_i[1:0]!=0 as an error: pslverr_o=1, no side effects, prdata_o=0.
REQ-019 SHALL implement the FSM states IDLE, ACCESS, WAIT_RD and RESP.
REQ-020 SHALL move IDLE->ACCESS when psel_i=1 and penable_i=0.
REQ-021 SHALL, in ACCESS, go to RESP for a write, for an error, for a STATUS read, or for a channel read with valid[i]=1.
REQ-022 SHALL, in ACCESS, go to WAIT_RD for a channel read with valid[i]=0, clearing the wait counter.
REQ-023 SHALL, in WAIT_RD, go to RESP with the newly captured data when ip2reg_en_i[i]=1.
REQ-024 SHALL, in WAIT_RD, go to RESP with pslverr_o=1 and prdata_o=0 when the counter reaches TIMEOUT.
REQ-025 SHALL otherwise increment the counter in WAIT_RD.
REQ-026 SHALL assert pready_o for exactly one cycle, in RESP, and then go to IDLE.
REQ-027 SHALL set minimum latency to pready_o=1 in the second access-phase cycle (one wait state).
REQ-028 SHALL, for a channel write, load reg2ip_data_o[i] with pwdata_i and pulse reg2ip_en_o[i] for one cycle, coincident with pready_o.
REQ-029 SHALL hold reg2ip_data_o between writes and keep all other en bits at 0.
REQ-030 SHALL, on every cycle with ip2reg_en_i[i]=1, capture ip2reg_data_i slice i into shadow[i] and set valid[i]=1, independent of FSM state.
REQ-031 SHALL clear valid[i] on completion of a successful channel-i read, with prdata_o=shadow[i].
REQ-032 SHALL, on a STATUS write, clear each valid bit written with 1 (write-1-to-clear) and leave bits written with 0 unchanged.
REQ-033 SHALL resolve simultaneous capture and clear (read or W1C) on the same channel in favour of capture: valid stays 1, and the read returns the old shadow.
REQ-034 SHALL hold prdata_o=0 and pslverr_o=0 whenever pready_o=0.
REQ-035 SHALL, if psel_i drops before RESP, abandon the transfer and return to IDLE with no strobe and no valid change.

Reset
REQ-036 SHALL, while rst_i=1 at a clock edge, set state=IDLE, counter=0, shadow=0, valid=0, reg2ip_data_o=0, reg2ip_en_o=0, prdata_o=0, pready_o=0 and pslverr_o=0.
REQ-037 SHALL abort any in-flight transfer on reset, with no pready_o and no reg2ip_en_o pulse.

Verification
REQ-038 SHALL cover a write of 0xDEADBEEF to addr 0x4: reg2ip_data_o[63:32]=0xDEADBEEF, reg2ip_en_o=3'b010 for one cycle with pready_o, pslverr_o=0.
REQ-039 SHALL cover ip2reg_en_i=3'b001 with data 0x12345678, then a read of addr 0x0: prdata_o=0x12345678 after one wait state, and a subsequent STATUS read returns 0x0.
REQ-040 SHALL cover a read of addr 0x8 with ip2reg_en_i[2] pulsed 5 cycles later with 0xA5A5A5A5: pready_o occurs in the cycle after the pulse, prdata_o=0xA5A5A5A5.
REQ-041 SHALL cover a read of addr 0x8 with no capture and TIMEOUT=16: pready_o=1 and pslverr_o=1 after 16 WAIT_RD cycles, prdata_o=0.
REQ-042 SHALL cover valid=3'b111, a STATUS write of 0x5 with ip2reg_en_i[0] in the same cycle: a STATUS read returns 0x3.
REQ-043 SHALL cover rst_i=1 during WAIT_RD: all outputs are 0 the next cycle, no pready_o, and a following STATUS read returns 0x0.
